// File: rtl/ctrl_rom_pkg.sv
// ctrl_rom_pkg
// Shared definitions for the control ROM writer:
//   - default ROM geometry (word address width, control word width)
//   - stream framing constants (length bytes, bytes per word)
//   - FSM state encoding plus small state-classification helpers
// Optional feature macro: CTRL_ROM_CHECKSUM_EN adds the SUM state.
package ctrl_rom_pkg;

    localparam int CTRL_ROM_ADDR_W = 17;  // {ext, opcode[7:0], flags[3:0], step[3:0]}
    localparam int CTRL_ROM_WORD_W = 32;
    localparam int LEN_BYTES       = 3;   // little-endian word count
    localparam int BYTES_PER_WORD  = 4;   // little-endian control word
    localparam int LEN_W           = 8 * LEN_BYTES;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LEN   = 3'd1,
        ST_DATA  = 3'd2,
        ST_WRITE = 3'd3,
`ifdef CTRL_ROM_CHECKSUM_EN
        ST_SUM   = 3'd4,
`endif
        ST_FIN   = 3'd5
    } ctrl_state_e;

    // States in which the stream port may accept a byte.
    function automatic logic state_takes_bytes(input ctrl_state_e s);
        logic r;
        r = 1'b0;
        case (s)
            ST_LEN, ST_DATA: r = 1'b1;
`ifdef CTRL_ROM_CHECKSUM_EN
            ST_SUM:          r = 1'b1;
`endif
            default:         r = 1'b0;
        endcase
        return r;
    endfunction

    // States that belong to an active load (CPU control word tri-stated).
    function automatic logic state_is_loading(input ctrl_state_e s);
        logic r;
        r = 1'b0;
        case (s)
            ST_LEN, ST_DATA, ST_WRITE: r = 1'b1;
`ifdef CTRL_ROM_CHECKSUM_EN
            ST_SUM:                    r = 1'b1;
`endif
            default:                   r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/ctrl_word_packer.sv
// ctrl_word_packer
// Assembles little-endian bytes into a control word. The first byte of a
// word ends up in bits [7:0]. word_done_o pulses combinationally on the
// cycle the last byte of a word is presented, with word_o holding the
// complete word on that same cycle, so the caller can latch it directly.
// Ports:
//   clk_i        clock, rising edge
//   rst_i        synchronous active-high reset
//   clear_i      restart assembly at byte 0 (new load)
//   byte_valid_i byte_i is consumed this cycle
//   byte_i       stream byte
//   word_o       assembled word (valid when word_done_o)
//   word_done_o  last byte of a word consumed this cycle
module ctrl_word_packer
    import ctrl_rom_pkg::*;
#(
    parameter int WORD_W = CTRL_ROM_WORD_W
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clear_i,
    input  logic              byte_valid_i,
    input  logic [7:0]        byte_i,
    output logic [WORD_W-1:0] word_o,
    output logic              word_done_o
);

    logic [1:0]        byte_idx_q;
    // Only the upper bytes are kept; the newest byte is supplied live.
    logic [WORD_W-9:0] shift_q;

    assign word_o      = {byte_i, shift_q};
    assign word_done_o = byte_valid_i && (byte_idx_q == 2'(BYTES_PER_WORD - 1));

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            byte_idx_q <= 2'd0;
            shift_q    <= '0;
        end else if (byte_valid_i) begin
            byte_idx_q <= byte_idx_q + 2'd1;   // wraps to 0 after a full word
            shift_q    <= word_o[WORD_W-1:8];
        end
    end

endmodule

// File: rtl/control_rom_writer.sv
// control_rom_writer
// Loads a control ROM from a byte stream: 3 length bytes (word count N,
// little-endian), then N words of 4 little-endian bytes, each written with
// a one-cycle rom_we strobe at addresses 0..N-1. While loading, cpu_hold
// keeps the control logic's control word tri-stated.
// Optional feature macro: CTRL_ROM_CHECKSUM_EN appends one checksum byte;
// the load succeeds only if the 8-bit sum of all bytes including it is 0.
// Without the macro, a load that completes all writes simply succeeds.
// Ports:
//   iclk      clock, rising edge
//   rst       synchronous active-high reset (wins over start/in_valid)
//   start     one-cycle load request, honoured in IDLE or FIN
//   in_data   stream byte; in_valid qualifies it
//   in_ready  byte accepted when in_valid && in_ready
//   rom_addr  write address, holds last value outside WRITE
//   rom_data  write data, holds last value outside WRITE
//   rom_we    one-cycle write strobe
//   busy      load in progress
//   cpu_hold  control-logic ctrlen while loading
//   done      sticky success flag
//   err       sticky failure flag (oversized length or bad checksum)
// Stream handshake: a byte transfers on a rising edge where in_valid and
// in_ready are both 1; in_valid low simply stalls the FSM.
module control_rom_writer
    import ctrl_rom_pkg::*;
#(
    parameter int ADDR_W = CTRL_ROM_ADDR_W,
    parameter int WORD_W = CTRL_ROM_WORD_W
) (
    input  logic              iclk,
    input  logic              rst,
    input  logic              start,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [ADDR_W-1:0] rom_addr,
    output logic [WORD_W-1:0] rom_data,
    output logic              rom_we,
    output logic              busy,
    output logic              cpu_hold,
    output logic              done,
    output logic              err
);

`ifdef CTRL_ROM_CHECKSUM_EN
    localparam ctrl_state_e POST_STATE = ST_SUM;
`else
    localparam ctrl_state_e POST_STATE = ST_FIN;
`endif

    // Largest legal word count is 2^ADDR_W (last address all-ones).
    localparam logic [LEN_W:0] MAX_WORDS = {{LEN_W{1'b0}}, 1'b1} << ADDR_W;

    ctrl_state_e       state_q, state_d;
    logic [1:0]        len_cnt_q;
    logic [LEN_W-1:0]  len_q;
    logic [ADDR_W-1:0] word_idx_q;
    logic              in_ready_q, busy_q, cpu_hold_q, done_q, err_q, rom_we_q;
    logic [ADDR_W-1:0] rom_addr_q;
    logic [WORD_W-1:0] rom_data_q;

    logic              accept, start_ok;
    logic              len_last, len_too_big, len_zero, word_last;
    logic [LEN_W-1:0]  len_full;
    logic              set_err, set_done;
    logic [WORD_W-1:0] packed_word;
    logic              word_done;

`ifdef CTRL_ROM_CHECKSUM_EN
    logic [7:0]        sum_q;
    logic [7:0]        sum_final;
    assign sum_final = sum_q + in_data;
`endif

    assign accept   = in_valid && in_ready_q;
    assign start_ok = start && (state_q == ST_IDLE || state_q == ST_FIN);

    // Length as it stands once the third byte lands this cycle.
    assign len_full    = {in_data, len_q[15:0]};
    assign len_last    = (len_cnt_q == 2'(LEN_BYTES - 1));
    assign len_too_big = ({1'b0, len_full} > MAX_WORDS);
    assign len_zero    = (len_full == '0);
    assign word_last   = (len_q == LEN_W'(word_idx_q) + LEN_W'(1));

    ctrl_word_packer #(
        .WORD_W (WORD_W)
    ) u_packer (
        .clk_i        (iclk),
        .rst_i        (rst),
        .clear_i      (start_ok),
        .byte_valid_i (accept && state_q == ST_DATA),
        .byte_i       (in_data),
        .word_o       (packed_word),
        .word_done_o  (word_done)
    );

    always_comb begin
        state_d = state_q;
        if (start_ok) begin
            state_d = ST_LEN;
        end else begin
            case (state_q)
                ST_LEN: begin
                    if (accept && len_last) begin
                        if (len_too_big)   state_d = ST_FIN;
                        else if (len_zero) state_d = POST_STATE;
                        else               state_d = ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (accept && word_done) state_d = ST_WRITE;
                end
                ST_WRITE: begin
                    state_d = word_last ? POST_STATE : ST_DATA;
                end
`ifdef CTRL_ROM_CHECKSUM_EN
                ST_SUM: begin
                    if (accept) state_d = ST_FIN;
                end
`endif
                ST_IDLE, ST_FIN: state_d = state_q;
                default:         state_d = ST_IDLE;
            endcase
        end
    end

    // Failure is decided on the transition into FIN; any other entry into
    // FIN is a success, which keeps done and err mutually exclusive.
    always_comb begin
        set_err = 1'b0;
        if (!start_ok) begin
            if (state_q == ST_LEN && accept && len_last && len_too_big) set_err = 1'b1;
`ifdef CTRL_ROM_CHECKSUM_EN
            if (state_q == ST_SUM && accept && sum_final != 8'h00) set_err = 1'b1;
`endif
        end
        set_done = (state_d == ST_FIN) && (state_q != ST_FIN) && !set_err;
    end

    always_ff @(posedge iclk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            cpu_hold_q <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            rom_we_q   <= 1'b0;
            rom_addr_q <= '0;
            rom_data_q <= '0;
            len_cnt_q  <= 2'd0;
            len_q      <= '0;
            word_idx_q <= '0;
`ifdef CTRL_ROM_CHECKSUM_EN
            sum_q      <= 8'h00;
`endif
        end else begin
            state_q    <= state_d;
            // Outputs follow the state being entered so they line up with it.
            in_ready_q <= state_takes_bytes(state_d);
            busy_q     <= state_is_loading(state_d);
            cpu_hold_q <= state_is_loading(state_d);
            rom_we_q   <= (state_d == ST_WRITE);

            if (state_q == ST_DATA && state_d == ST_WRITE) begin
                rom_addr_q <= word_idx_q;
                rom_data_q <= packed_word;
            end

            if (start_ok) begin
                done_q     <= 1'b0;
                err_q      <= 1'b0;
                len_cnt_q  <= 2'd0;
                len_q      <= '0;
                word_idx_q <= '0;
`ifdef CTRL_ROM_CHECKSUM_EN
                sum_q      <= 8'h00;
`endif
            end else begin
                if (set_err)  err_q  <= 1'b1;
                if (set_done) done_q <= 1'b1;

                if (state_q == ST_LEN && accept) begin
                    case (len_cnt_q)
                        2'd0:    len_q[7:0]   <= in_data;
                        2'd1:    len_q[15:8]  <= in_data;
                        default: len_q[23:16] <= in_data;
                    endcase
                    len_cnt_q <= len_cnt_q + 2'd1;
                end

`ifdef CTRL_ROM_CHECKSUM_EN
                if ((state_q == ST_LEN || state_q == ST_DATA) && accept) begin
                    sum_q <= sum_q + in_data;
                end
`endif

                // Advance only when another word follows, so the index
                // never wraps past the last address.
                if (state_q == ST_WRITE && !word_last) begin
                    word_idx_q <= word_idx_q + 1'b1;
                end
            end
        end
    end

    assign in_ready = in_ready_q;
    assign busy     = busy_q;
    assign cpu_hold = cpu_hold_q;
    assign done     = done_q;
    assign err      = err_q;
    assign rom_we   = rom_we_q;
    assign rom_addr = rom_addr_q;
    assign rom_data = rom_data_q;

endmodule

// File: tb/tb_control_rom_writer.sv
// Testbench for control_rom_writer. Inputs change on the falling edge,
// outputs are sampled on the falling edge. ROM writes are captured into
// got_q and compared against the expected queue exp_q.
// Builds with or without CTRL_ROM_CHECKSUM_EN.
module tb_control_rom_writer;

    localparam int ADDR_W = 17;
    localparam int WORD_W = 32;
    localparam int E_W    = ADDR_W + WORD_W;

    logic              iclk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [7:0]        in_data = 8'h00;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [ADDR_W-1:0] rom_addr;
    logic [WORD_W-1:0] rom_data;
    logic              rom_we;
    logic              busy;
    logic              cpu_hold;
    logic              done;
    logic              err;

    int checks = 0;
    int errors = 0;

    logic [E_W-1:0] exp_q[$];
    logic [E_W-1:0] got_q[$];

    control_rom_writer #(
        .ADDR_W (ADDR_W),
        .WORD_W (WORD_W)
    ) dut (
        .iclk     (iclk),
        .rst      (rst),
        .start    (start),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .rom_addr (rom_addr),
        .rom_data (rom_data),
        .rom_we   (rom_we),
        .busy     (busy),
        .cpu_hold (cpu_hold),
        .done     (done),
        .err      (err)
    );

    // ---------------- clock / watchdog ----------------
    always #5 iclk = ~iclk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // ---------------- write monitor ----------------
    always @(negedge iclk) begin
        if (rom_we === 1'b1) got_q.push_back({rom_addr, rom_data});
    end

    // ---------------- driver tasks ----------------
    // All driver tasks are entered and left at a falling edge.
    task automatic pulse_start();
        start = 1'b1;
        @(negedge iclk);
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int t;
        t = 0;
        in_data  = b;
        in_valid = 1'b1;
        while (in_ready !== 1'b1 && t < 100) begin
            @(negedge iclk);
            t++;
        end
        if (t >= 100) begin
            checks++;
            errors++;
            $display("FAIL send_byte_timeout: in_ready stayed %b, need 1", in_ready);
        end
        @(negedge iclk);
    endtask

    task automatic go_idle();
        in_valid = 1'b0;
    endtask

    task automatic wait_not_busy();
        int t;
        t = 0;
        while (busy !== 1'b0 && t < 100) begin
            @(negedge iclk);
            t++;
        end
        if (t >= 100) begin
            checks++;
            errors++;
            $display("FAIL wait_not_busy_timeout: busy stayed %b, need 0", busy);
        end
        @(negedge iclk);
    endtask

    task automatic send_word(input logic [31:0] w, input bit gap);
        for (int i = 0; i < 4; i++) begin
            send_byte(w[8*i +: 8]);
            if (gap) begin
                in_valid = 1'b0;
                @(negedge iclk);
            end
        end
    endtask

    task automatic clear_sb();
        exp_q.delete();
        got_q.delete();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge iclk);
        checks++;
        if ({rom_we, busy, cpu_hold, done, err, in_ready} !== 6'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b need 000000", {rom_we, busy, cpu_hold, done, err, in_ready});
        end
        checks++;
        if (rom_addr !== '0 || rom_data !== '0) begin
            errors++;
            $display("FAIL reset_bus: got addr=%h data=%h need 0/0", rom_addr, rom_data);
        end
        rst = 1'b0;
        @(negedge iclk);
        checks++;
        if (in_ready !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_outputs: got in_ready=%b busy=%b need 0/0", in_ready, busy);
        end
    endtask

    task automatic test_two_words();
        clear_sb();
        exp_q.push_back({17'd0, 32'h12345678});
        exp_q.push_back({17'd1, 32'hDEADBEEF});
        pulse_start();
        send_byte(8'h02); send_byte(8'h00); send_byte(8'h00);
        checks++;
        if (busy !== 1'b1 || cpu_hold !== 1'b1) begin
            errors++;
            $display("FAIL two_words_hold: got busy=%b cpu_hold=%b need 1/1", busy, cpu_hold);
        end
        send_word(32'h12345678, 1'b0);
        send_word(32'hDEADBEEF, 1'b0);
`ifdef CTRL_ROM_CHECKSUM_EN
        send_byte(8'hB2);
`endif
        go_idle();
        wait_not_busy();
        checks++;
        if (got_q.size() !== exp_q.size()) begin
            errors++;
            $display("FAIL two_words_count: got %0d writes need %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL two_words_write%0d: got %h need %h", i, got_q[i], exp_q[i]);
            end
        end
        checks++;
        if ({done, err, cpu_hold, busy, in_ready} !== 5'b10000) begin
            errors++;
            $display("FAIL two_words_status: got done/err/hold/busy/rdy=%b need 10000", {done, err, cpu_hold, busy, in_ready});
        end
        checks++;
        if (rom_addr !== 17'd1 || rom_data !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL two_words_hold_bus: got %h/%h need 00001/deadbeef", rom_addr, rom_data);
        end
    endtask

    task automatic test_bad_checksum();
`ifdef CTRL_ROM_CHECKSUM_EN
        clear_sb();
        exp_q.push_back({17'd0, 32'h12345678});
        exp_q.push_back({17'd1, 32'hDEADBEEF});
        pulse_start();
        send_byte(8'h02); send_byte(8'h00); send_byte(8'h00);
        send_word(32'h12345678, 1'b0);
        send_word(32'hDEADBEEF, 1'b0);
        send_byte(8'hB3);
        go_idle();
        wait_not_busy();
        checks++;
        if (got_q.size() !== exp_q.size()) begin
            errors++;
            $display("FAIL bad_sum_count: got %0d writes need %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL bad_sum_write%0d: got %h need %h", i, got_q[i], exp_q[i]);
            end
        end
        checks++;
        if ({done, err} !== 2'b01) begin
            errors++;
            $display("FAIL bad_sum_flags: got done/err=%b need 01", {done, err});
        end
`endif
    endtask

    task automatic test_zero_len();
        clear_sb();
        pulse_start();
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL zero_len_done_cleared: got %b need 0", done);
        end
        send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
`ifdef CTRL_ROM_CHECKSUM_EN
        send_byte(8'h00);
`endif
        go_idle();
        wait_not_busy();
        checks++;
        if (got_q.size() !== 0) begin
            errors++;
            $display("FAIL zero_len_writes: got %0d need 0", got_q.size());
        end
        checks++;
        if ({done, err} !== 2'b10) begin
            errors++;
            $display("FAIL zero_len_flags: got done/err=%b need 10", {done, err});
        end
    endtask

    task automatic test_too_big();
        clear_sb();
        pulse_start();
        send_byte(8'h01); send_byte(8'h00); send_byte(8'h02);  // N = 0x020001
        in_data = 8'hAA;                                       // keep offering bytes
        repeat (3) @(negedge iclk);
        go_idle();
        checks++;
        if (got_q.size() !== 0) begin
            errors++;
            $display("FAIL too_big_writes: got %0d need 0", got_q.size());
        end
        checks++;
        if ({done, err, in_ready, busy} !== 4'b0100) begin
            errors++;
            $display("FAIL too_big_status: got done/err/rdy/busy=%b need 0100", {done, err, in_ready, busy});
        end
    endtask

    task automatic test_stall();
        for (int pass = 0; pass < 2; pass++) begin
            clear_sb();
            exp_q.push_back({17'd0, 32'hCAFEF00D});
            pulse_start();
            send_byte(8'h01);
            if (pass == 1) begin in_valid = 1'b0; @(negedge iclk); end
            send_byte(8'h00);
            if (pass == 1) begin in_valid = 1'b0; @(negedge iclk); end
            send_byte(8'h00);
            if (pass == 1) begin in_valid = 1'b0; @(negedge iclk); end
            send_word(32'hCAFEF00D, pass == 1);
`ifdef CTRL_ROM_CHECKSUM_EN
            send_byte(8'h3A);
`endif
            go_idle();
            wait_not_busy();
            checks++;
            if (got_q.size() !== 1) begin
                errors++;
                $display("FAIL stall%0d_count: got %0d writes need 1", pass, got_q.size());
            end
            if (got_q.size() > 0) begin
                checks++;
                if (got_q[0] !== exp_q[0]) begin
                    errors++;
                    $display("FAIL stall%0d_write: got %h need %h", pass, got_q[0], exp_q[0]);
                end
            end
            checks++;
            if ({done, err} !== 2'b10) begin
                errors++;
                $display("FAIL stall%0d_flags: got done/err=%b need 10", pass, {done, err});
            end
        end
    endtask

    task automatic test_reset_mid_load();
        clear_sb();
        exp_q.push_back({17'd0, 32'h44332211});
        pulse_start();
        send_byte(8'h03); send_byte(8'h00); send_byte(8'h00);
        send_word(32'h44332211, 1'b0);
        send_byte(8'h55);
        // Reset together with a start pulse and a valid byte.
        rst      = 1'b1;
        start    = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'h66;
        @(negedge iclk);
        checks++;
        if ({rom_we, busy, cpu_hold, done, err, in_ready} !== 6'b0 || rom_addr !== '0 || rom_data !== '0) begin
            errors++;
            $display("FAIL mid_reset_outputs: got flags=%b addr=%h data=%h need 0", {rom_we, busy, cpu_hold, done, err, in_ready}, rom_addr, rom_data);
        end
        rst      = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        repeat (4) @(negedge iclk);
        checks++;
        if (busy !== 1'b0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_start_ignored: got busy=%b in_ready=%b need 0/0", busy, in_ready);
        end
        checks++;
        if (got_q.size() !== 1) begin
            errors++;
            $display("FAIL mid_reset_count: got %0d writes need 1", got_q.size());
        end
        if (got_q.size() > 0) begin
            checks++;
            if (got_q[0] !== exp_q[0]) begin
                errors++;
                $display("FAIL mid_reset_write: got %h need %h", got_q[0], exp_q[0]);
            end
        end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        @(negedge iclk);
        test_reset();
        test_two_words();
        test_bad_checksum();
        test_zero_len();
        test_too_big();
        test_stall();
        test_reset_mid_load();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
